// File: rtl/flag_unit.sv
// flag_unit: owns the architectural {V,Z,N} flag register consumed by the
// branch resolver. Captures ALU flags from EX under per-opcode write masks,
// honours pipe_stall/ex_flush, and resolves the EX-writer vs ID-branch flag
// hazard either by forwarding (FWD=1) or by stalling the branch (FWD=0).
//
// Parameters:
//   FWD    1 = forward EX flags to a same-cycle branch, 0 = stall one cycle
//   CNT_W  width of the saturating hazard-stall counter
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   ex_valid, ex_opcode         EX instruction qualifier and opcode
//   alu_n, alu_z, alu_v         raw ALU flags of the EX instruction
//   pipe_stall, ex_flush        pipeline control for the EX stage
//   br_req                      ID holds a flag-consuming branch
//   flags                       {V,Z,N} to the branch resolver
//   br_stall                    ID must hold the branch this cycle
//   stall_cnt                   saturating count of br_stall cycles
module flag_unit #(
  parameter int unsigned FWD   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_v,
  input  logic             pipe_stall,
  input  logic             ex_flush,
  input  logic             br_req,
  output logic [2:0]       flags,
  output logic             br_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {
    IDLE    = 1'b0,
    RESOLVE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] mask;
  logic [2:0] alu_flags;
  logic [2:0] merged;
  logic       we;
  logic       haz;

  assign alu_flags = {alu_v, alu_z, alu_n};

  always_comb begin
    mask = 3'b000;
    unique case (ex_opcode)
      4'b0000, 4'b0001:                   mask = 3'b111;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: mask = 3'b010;
      default:                            mask = 3'b000;
    endcase
  end

  // Flush outranks everything: a squashed instruction neither writes nor hazards.
  assign we     = ex_valid & ~ex_flush & (mask != 3'b000);
  assign haz    = br_req & we;
  assign merged = (flags_q & ~mask) | (alu_flags & mask);

  always_comb begin
    flags_d = flags_q;
    if (we && !pipe_stall) begin
      flags_d = merged;
    end
  end

  always_comb begin
    state_d  = state_q;
    br_stall = 1'b0;
    flags    = flags_q;
    if (FWD != 0) begin
      // Forward path is purely combinational and ignores reset.
      flags   = haz ? merged : flags_q;
      state_d = IDLE;
    end else begin
      if (!rst_n) begin
        flags = '0;
      end
      unique case (state_q)
        IDLE: begin
          br_stall = haz & rst_n;
          // Under pipe_stall the writer has not committed yet; keep stalling.
          if (haz && !pipe_stall) begin
            state_d = RESOLVE;
          end
        end
        RESOLVE: begin
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (br_stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flags_q <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      flags_q <= flags_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: three instances (forwarding, stalling,
// stalling with a 2-bit counter) share one stimulus stream and are compared
// every cycle against a behavioural model, plus directed scenario checks.
module tb_flag_unit;

  logic       clk;
  logic       rst_n;
  logic       ex_valid;
  logic [3:0] ex_opcode;
  logic       alu_n, alu_z, alu_v;
  logic       pipe_stall;
  logic       ex_flush;
  logic       br_req;

  logic [2:0]  fl_f1, fl_f0, fl_s;
  logic        st_f1, st_f0, st_s;
  logic [15:0] cnt_f1, cnt_f0;
  logic [1:0]  cnt_s;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // model state per instance: 0 = forwarding, 1 = stalling, 2 = small counter
  logic [2:0]  m_flags [3];
  int unsigned m_cnt   [3];
  bit          m_res   [3];
  int unsigned m_max   [3];
  bit          m_fwd   [3];

  flag_unit #(.FWD(1), .CNT_W(16)) u_f1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .pipe_stall(pipe_stall),
    .ex_flush(ex_flush), .br_req(br_req), .flags(fl_f1), .br_stall(st_f1),
    .stall_cnt(cnt_f1)
  );

  flag_unit #(.FWD(0), .CNT_W(16)) u_f0 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .pipe_stall(pipe_stall),
    .ex_flush(ex_flush), .br_req(br_req), .flags(fl_f0), .br_stall(st_f0),
    .stall_cnt(cnt_f0)
  );

  flag_unit #(.FWD(0), .CNT_W(2)) u_s (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v), .pipe_stall(pipe_stall),
    .ex_flush(ex_flush), .br_req(br_req), .flags(fl_s), .br_stall(st_s),
    .stall_cnt(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] mask_of(input logic [3:0] op);
    int unsigned o;
    o = op;
    if (o < 2) return 3'b111;
    if (o == 2 || (o >= 4 && o <= 6)) return 3'b010;
    return 3'b000;
  endfunction

  task automatic drive(input bit v, input logic [3:0] op, input logic [2:0] alu,
                       input bit ps, input bit fl, input bit br, input bit rn);
    ex_valid   = v;
    ex_opcode  = op;
    {alu_v, alu_z, alu_n} = alu;
    pipe_stall = ps;
    ex_flush   = fl;
    br_req     = br;
    rst_n      = rn;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_flags[i] = 3'b000;
      m_cnt[i]   = 0;
      m_res[i]   = 1'b0;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic [2:0] m, mg, exp_f, got_f;
    bit         we, haz, exp_s, got_s;
    logic [31:0] got_c;
    @(negedge clk);
    m   = mask_of(ex_opcode);
    we  = ex_valid && !ex_flush && (m != 3'b000);
    haz = br_req && we;
    for (int i = 0; i < 3; i++) begin
      mg = (m_flags[i] & ~m) | ({alu_v, alu_z, alu_n} & m);
      if (m_fwd[i]) begin
        exp_f = haz ? mg : m_flags[i];
        exp_s = 1'b0;
      end else if (!rst_n) begin
        exp_f = 3'b000;
        exp_s = 1'b0;
      end else begin
        exp_f = m_flags[i];
        exp_s = haz && !m_res[i];
      end
      got_f = (i == 0) ? fl_f1 : (i == 1) ? fl_f0 : fl_s;
      got_s = (i == 0) ? st_f1 : (i == 1) ? st_f0 : st_s;
      got_c = (i == 0) ? 32'(cnt_f1) : (i == 1) ? 32'(cnt_f0) : 32'(cnt_s);
      check($sformatf("flags[%0d]", i), 32'(got_f), 32'(exp_f));
      check($sformatf("br_stall[%0d]", i), 32'(got_s), 32'(exp_s));
      check($sformatf("stall_cnt[%0d]", i), got_c, m_cnt[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      mg = (m_flags[i] & ~m) | ({alu_v, alu_z, alu_n} & m);
      if (!rst_n) begin
        m_flags[i] = 3'b000;
        m_cnt[i]   = 0;
        m_res[i]   = 1'b0;
      end else begin
        if (!m_fwd[i] && haz && !m_res[i] && m_cnt[i] < m_max[i]) m_cnt[i]++;
        if (we && !pipe_stall) m_flags[i] = mg;
        // a stalled branch resolves on the cycle after its writer commits
        m_res[i] = !m_fwd[i] && !m_res[i] && haz && !pipe_stall;
      end
    end
    #1;
  endtask

  task automatic idle_cycle();
    drive(0, 4'h0, 3'b000, 0, 0, 0, 1);
    cycle();
  endtask

  task automatic reset_seq();
    drive(0, 4'h0, 3'b000, 0, 0, 0, 0);
    cycle();
    cycle();
  endtask

  initial begin
    m_fwd[0] = 1'b1; m_max[0] = 65535;
    m_fwd[1] = 1'b0; m_max[1] = 65535;
    m_fwd[2] = 1'b0; m_max[2] = 3;
    drive(0, 4'h0, 3'b000, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    model_reset();

    // reset then idle
    reset_seq();
    drive(0, 4'h0, 3'b000, 0, 0, 0, 1);
    #2;
    check("idle_flags", 32'(fl_f0), 32'h0);
    check("idle_stall", 32'(st_f0), 32'h0);
    check("idle_cnt", 32'(cnt_f0), 32'h0);
    cycle();

    // masked writes: SUB 101, XOR 010 -> 111, RED holds
    drive(1, 4'b0001, 3'b101, 0, 0, 0, 1); cycle();
    drive(1, 4'b0010, 3'b010, 0, 0, 0, 1);
    #2; check("after_sub", 32'(fl_f0), 32'h5);
    cycle();
    drive(1, 4'b0011, 3'b000, 0, 0, 0, 1);
    #2; check("after_xor", 32'(fl_f0), 32'h7);
    cycle();
    idle_cycle();
    check("after_red", 32'(fl_f0), 32'h7);

    // hazard: flags 000, ADD alu Z=1, branch in ID
    reset_seq();
    drive(1, 4'b0000, 3'b010, 0, 0, 1, 1);
    #2;
    check("fwd1_flags", 32'(fl_f1), 32'h2);
    check("fwd1_stall", 32'(st_f1), 32'h0);
    check("fwd0_stall", 32'(st_f0), 32'h1);
    cycle();
    drive(0, 4'h0, 3'b000, 0, 0, 1, 1);
    #2;
    check("fwd0_resolve_flags", 32'(fl_f0), 32'h2);
    check("fwd0_resolve_stall", 32'(st_f0), 32'h0);
    cycle();
    check("fwd0_cnt", 32'(cnt_f0), 32'h1);

    // flush with branch: no hazard
    drive(1, 4'b0001, 3'b111, 0, 1, 1, 1);
    #2;
    check("flush_stall", 32'(st_f0), 32'h0);
    check("flush_flags", 32'(fl_f1), 32'h2);
    cycle();
    // pipe_stall held 3 cycles: 3 + 1 stall cycles, then commit
    for (int k = 0; k < 3; k++) begin
      drive(1, 4'b0000, 3'b101, 1, 0, 1, 1);
      #2; check("pstall_stall", 32'(st_f0), 32'h1);
      check("pstall_fwd", 32'(fl_f1), 32'h5);
      cycle();
    end
    drive(1, 4'b0000, 3'b101, 0, 0, 1, 1);
    #2; check("pstall_last", 32'(st_f0), 32'h1);
    check("pstall_nocommit", 32'(fl_f0), 32'h2);
    cycle();
    idle_cycle();
    check("pstall_commit", 32'(fl_f0), 32'h5);
    check("pstall_cnt", 32'(cnt_f0), 32'h5);

    // saturation on the 2-bit counter, then reset mid-RESOLVE
    reset_seq();
    for (int k = 0; k < 5; k++) begin
      drive(1, 4'b0001, 3'(k), 0, 0, 1, 1); cycle();
      idle_cycle();
    end
    check("sat_cnt", 32'(cnt_s), 32'h3);
    check("sat_cnt_wide", 32'(cnt_f0), 32'h5);
    drive(1, 4'b0000, 3'b111, 0, 0, 1, 1); cycle();
    drive(0, 4'h0, 3'b000, 0, 0, 0, 0); cycle();
    check("rst_cnt", 32'(cnt_s), 32'h0);
    drive(1, 4'b0000, 3'b001, 0, 0, 1, 1);
    #2; check("rst_idle_stall", 32'(st_s), 32'h1);
    cycle();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(3, 0) != 0), 4'($urandom_range(15, 0)),
            3'($urandom_range(7, 0)), ($urandom_range(3, 0) == 0),
            ($urandom_range(7, 0) == 0), ($urandom_range(1, 0) == 1),
            ($urandom_range(60, 0) != 0));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flag_unit.md
# flag_unit

Producer side of the branch-condition interface: owns the architectural N/Z/V flag register that the branch resolver consumes as its 3-bit flag vector. It captures ALU flags from the EX stage under per-opcode write masks and honours pipeline stall/flush. It detects the flag hazard between a flag-writing instruction in EX and a branch in ID, then either forwards the new flags (FWD=1) or stalls the branch one cycle (FWD=0). It sits beside the ALU in EX; its `flags` output feeds the PC-control block in ID.

## Interface
- FWD, 1, 1 = forward EX flags to a same-cycle branch; 0 = stall the branch one cycle instead
- CNT_W, 16, width of the saturating hazard-stall counter
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- ex_valid  in  1  EX holds a real instruction
- ex_opcode  in  4  EX opcode
- alu_n / alu_z / alu_v  in  1 each  raw ALU flags for the EX instruction
- pipe_stall  in  1  global stall; EX does not advance this cycle
- ex_flush  in  1  EX instruction is squashed this cycle
- br_req  in  1  ID holds a conditional branch (condition != 3'b111) that needs flags this cycle
- flags  out  3  {V, Z, N}: bit2 = V, bit1 = Z, bit0 = N; goes to the branch resolver
- br_stall  out  1  ID must hold the branch this cycle
- stall_cnt  out  CNT_W  count of cycles where br_stall was asserted, saturating

## Operation
- Write masks, as {V, Z, N}:
  - ADD 0000 and SUB 0001: 3'b111.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: 3'b010.
  - RED 0011, PADDSB 0111, and all opcodes >= 1000: 3'b000.
- we = ex_valid & ~ex_flush & (mask != 0).
- Commit: when we & ~pipe_stall, each masked bit of flags_q takes the matching alu_* bit. Unmasked bits hold.
- Hazard: haz = br_req & we.
- FWD=1:
  - flags = haz ? merged : flags_q, where merged is flags_q with the masked bits replaced by alu_*. This path is combinational.
  - br_stall = 0 always.
- FWD=0, 2-state FSM:
  - IDLE: flags = flags_q. br_stall = haz. If haz & ~pipe_stall, go to RESOLVE. If haz & pipe_stall, stay in IDLE and keep br_stall = 1.
  - RESOLVE: flags = flags_q, which already holds the committed value. br_stall = 0. Return to IDLE next cycle unconditionally.
- ex_flush has priority over we. A flushed instruction never writes flags and never causes a hazard.
- stall_cnt increments on every cycle with br_stall = 1. It saturates at 2^CNT_W - 1 and does not wrap.
- Reset (rst_n = 0 at an edge):
  - flags_q = 3'b000, FSM = IDLE, stall_cnt = 0.
  - Outputs while in reset, with FWD=0: flags = 0, br_stall = 0.
  - Outputs while in reset, with FWD=1: br_stall = 0; `flags` follows the combinational forwarding rule, which stays in effect regardless of reset.
  - A reset during RESOLVE returns the FSM to IDLE with no commit.

## Timing
- Commit latency: flags_q shows the new value the cycle after the EX edge.
- FWD=1: zero-latency forward, valid in the same cycle. Branch penalty is 0.
- FWD=0: exactly 1 stall cycle per hazard, extended by any pipe_stall cycles. The branch reads the committed flags in the cycle after br_stall drops.
- Back-to-back flag writers: each commits in order. Only the youngest writer in EX is compared against ID.
- Simultaneous ex_flush and br_req: no hazard, so br_stall = 0 and flags = flags_q.
- pipe_stall with we: no commit, and the FWD=1 forward is still presented.

## Test plan
- Reset then idle: rst_n low for 2 cycles, then ex_valid = 0 -> flags = 3'b000, br_stall = 0, stall_cnt = 0.
- Masked write: SUB with alu {V,Z,N} = 101, then XOR with alu 010 -> flags_q = 101, then 111. Then RED with alu 000 -> flags_q stays 111.
- FWD=1 hazard: flags_q = 000, ADD in EX with alu Z = 1, br_req = 1 -> flags = 010 in the same cycle, br_stall = 0.
- FWD=0 hazard: same stimulus -> br_stall = 1 for 1 cycle, then flags = 010 with br_stall = 0. stall_cnt = 1.
- Flush and stall: SUB with ex_flush = 1 and br_req = 1 -> no stall, flags unchanged. ADD with pipe_stall held 3 cycles (FWD=0) -> br_stall held 3 cycles plus 1, then commit.
- Saturation: CNT_W = 2, force 5 hazards -> stall_cnt = 3. Then assert rst_n = 0 mid-RESOLVE -> FSM = IDLE, stall_cnt = 0.
